// File: rtl/hotel_pkg.sv
// Shared types and constants for the hotel checkout block: guest-table geometry,
// nightly rates, controller states and error codes.
package hotel_pkg;

   localparam int SLOTS  = 8;
   localparam int SLOT_W = $clog2(SLOTS);
   localparam int ID_W   = 4;
   localparam int DAYS_W = 3;
   localparam int BILL_W = 16;

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

   localparam logic [BILL_W-1:0] BASE_RATE = 16'd500;
   localparam logic [BILL_W-1:0] AC_RATE   = 16'd200;
   localparam logic [BILL_W-1:0] WIFI_RATE = 16'd100;

   typedef enum logic [2:0] {
      IDLE,
      SEARCH,
      CALC,
      PRESENT,
      RELEASE,
      ERR
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'b00,
      ERR_FULL      = 2'b01,
      ERR_DUP       = 2'b10,
      ERR_NOT_FOUND = 2'b11
   } err_code_t;

   typedef struct packed {
      logic              valid;
      logic [ID_W-1:0]   id;
      logic              ac;
      logic              wifi;
      logic [DAYS_W-1:0] days;
   } slot_t;

   // Returns {found, index} of the lowest-index clear bit.
   function automatic logic [SLOT_W:0] first_free(input logic [SLOTS-1:0] occ);
      logic [SLOT_W:0] res;
      res = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!occ[i]) res = {1'b1, SLOT_W'(i)};
      end
      return res;
   endfunction

endpackage

// File: rtl/hotel_rate_calc.sv
// Combinational charge for one stay: days * (base + ac + wifi rates).
// LONG_STAY_DISCOUNT_EN: stays of 5+ days get gross minus gross/8 (truncated).
module hotel_rate_calc
   import hotel_pkg::*;
(
   input  logic              ac,
   input  logic              wifi,
   input  logic [DAYS_W-1:0] days,
   output logic [BILL_W-1:0] bill
);

   logic [BILL_W-1:0] rate;
   logic [BILL_W-1:0] gross;

   // NOTE: every variable written here gets a value on every path, so no latch is inferred.
   always_comb begin
      rate  = BASE_RATE + (ac ? AC_RATE : '0) + (wifi ? WIFI_RATE : '0);
      gross = rate * BILL_W'(days);
`ifdef LONG_STAY_DISCOUNT_EN
      bill  = (days >= 3'd5) ? gross - (gross >> 3) : gross;
`else
      bill  = gross;
`endif
   end

endmodule

// File: rtl/hotel_checkout.sv
// Hotel checkout controller: 8-slot guest table, booking intake, sequential
// checkout search, billing and payment handshake. Honours LONG_STAY_DISCOUNT_EN.
module hotel_checkout
   import hotel_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              book_valid,
   input  logic [ID_W-1:0]   book_id,
   input  logic              book_ac,
   input  logic              book_wifi,
   input  logic [DAYS_W-1:0] book_days,
   output logic              book_ready,
   input  logic              checkout,
   input  logic [ID_W-1:0]   checkout_id,
   output logic              busy,
   output logic [BILL_W-1:0] bill,
   output logic              bill_valid,
   input  logic              pay_ack,
   output logic [SLOTS-1:0]  occupied,
   output logic              err,
   output logic [1:0]        err_code
);

   state_t            state;
   state_t            state_nxt;
   slot_t             slots [SLOTS];
   logic [SLOT_W-1:0] scan_idx;
   logic [SLOT_W-1:0] match_idx;
   logic [ID_W-1:0]   ck_id;
   logic [SLOT_W:0]   free_info;
   logic              free_avail;
   logic [SLOT_W-1:0] free_idx;
   logic              dup;
   logic              book_write;
   logic              book_err;
   err_code_t         book_code;
   logic              scan_hit;
   logic              scan_last;
   logic              enter_err;
   logic [BILL_W-1:0] charge;

   // ---------------- table status ----------------
   always_comb begin
      occupied = '0;
      dup      = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         occupied[i] = slots[i].valid;
         if (slots[i].valid && (slots[i].id == book_id)) dup = 1'b1;
      end
   end

   assign free_info  = first_free(occupied);
   assign free_avail = free_info[SLOT_W];
   assign free_idx   = free_info[SLOT_W-1:0];

   // A duplicate id is refused even while a slot is free; it outranks "full".
   assign book_ready = free_avail && (state != RELEASE);
   assign book_write = book_valid && book_ready && !dup;
   assign book_err   = book_valid && (dup || !free_avail);
   assign book_code  = dup ? ERR_DUP : ERR_FULL;

   assign scan_hit   = slots[scan_idx].valid && (slots[scan_idx].id == ck_id);
   assign scan_last  = (scan_idx == LAST_SLOT);
   assign enter_err  = (state == SEARCH) && (state_nxt == ERR);

   // ---------------- FSM ----------------
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (checkout) state_nxt = SEARCH;
         SEARCH: begin
            if (scan_hit)       state_nxt = CALC;
            else if (scan_last) state_nxt = ERR;
         end
         CALC:    state_nxt = PRESENT;
         PRESENT: if (pay_ack) state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      bill_valid = (state == PRESENT);
   end

   // ---------------- guest table ----------------
   // NOTE: the table is reset because a stale valid bit would resurrect a departed guest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
      end else begin
         if (state == RELEASE) slots[match_idx].valid <= 1'b0;
         if (book_write) begin
            slots[free_idx] <= '{valid: 1'b1, id: book_id, ac: book_ac,
                                 wifi: book_wifi, days: book_days};
         end
      end
   end

   // ---------------- search / billing datapath ----------------
   hotel_rate_calc u_rate (
      .ac   (slots[match_idx].ac),
      .wifi (slots[match_idx].wifi),
      .days (slots[match_idx].days),
      .bill (charge)
   );

   // Slots booked mid-search are only seen if the scan has not passed them yet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_idx  <= '0;
         match_idx <= '0;
         ck_id     <= '0;
         bill      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (checkout) begin
                  ck_id    <= checkout_id;
                  scan_idx <= '0;
               end
            end
            SEARCH: begin
               if (scan_hit) match_idx <= scan_idx;
               else          scan_idx  <= scan_idx + 1'b1;
            end
            CALC:    bill <= charge;
            RELEASE: bill <= '0;
            default: ;
         endcase
      end
   end

   // Error pulse; a failed checkout search outranks a same-cycle booking error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else if (enter_err) begin
         err      <= 1'b1;
         err_code <= ERR_NOT_FOUND;
      end else if (book_err) begin
         err      <= 1'b1;
         err_code <= book_code;
      end else begin
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end
   end

endmodule

// File: tb/tb_hotel_checkout.sv
// Self-checking bench for hotel_checkout: timeline model of the guest table and
// checkout timing, per-cycle compare, plus directed literal expectations.
module tb_hotel_checkout;

   logic       clk;
   logic       rst_n;
   logic       book_valid;
   logic [3:0] book_id;
   logic       book_ac;
   logic       book_wifi;
   logic [2:0] book_days;
   logic       book_ready;
   logic       checkout;
   logic [3:0] checkout_id;
   logic       busy;
   logic [15:0] bill;
   logic       bill_valid;
   logic       pay_ack;
   logic [7:0] occupied;
   logic       err;
   logic [1:0] err_code;

`ifdef LONG_STAY_DISCOUNT_EN
   localparam int BILL_ID2  = 3500;
   localparam int BILL_ID7  = 3150;
   localparam int BILL_ID14 = 4288;
`else
   localparam int BILL_ID2  = 4000;
   localparam int BILL_ID7  = 3600;
   localparam int BILL_ID14 = 4900;
`endif

   hotel_checkout dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .book_valid  (book_valid),
      .book_id     (book_id),
      .book_ac     (book_ac),
      .book_wifi   (book_wifi),
      .book_days   (book_days),
      .book_ready  (book_ready),
      .checkout    (checkout),
      .checkout_id (checkout_id),
      .busy        (busy),
      .bill        (bill),
      .bill_valid  (bill_valid),
      .pay_ack     (pay_ack),
      .occupied    (occupied),
      .err         (err),
      .err_code    (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
   endtask

   function automatic int charge_of(input bit ac, input bit wifi, input int days);
      int g;
      g = days * (500 + (ac ? 200 : 0) + (wifi ? 100 : 0));
`ifdef LONG_STAY_DISCOUNT_EN
      if (days >= 5) g = g - g / 8;
`endif
      return g;
   endfunction

   // ---------------- model: guest table + checkout timeline ----------------
   int       cyc = 0;
   bit       m_valid [8];
   bit [3:0] m_id    [8];
   bit       m_ac    [8];
   bit       m_wifi  [8];
   int       m_days  [8];
   bit       ck_on   = 0;
   bit       ck_miss = 0;
   int       ck_t0   = 0;
   int       ck_k    = -1;
   int       ck_paid = -1;
   bit [3:0] ck_idm  = 0;
   bit       e_err   = 0;
   bit [1:0] e_code  = 0;

   always @(posedge clk or negedge rst_n) begin
      bit dup, full, releasing, do_wr;
      int wr_idx, j;
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_valid[i] = 0;
         ck_on = 0; ck_miss = 0; ck_k = -1; ck_paid = -1;
         e_err = 0; e_code = 0;
      end else begin
         cyc++;
         dup = 0; wr_idx = -1;
         for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_id[i] == book_id) dup = 1;
            if (!m_valid[i] && wr_idx < 0) wr_idx = i;
         end
         full      = (wr_idx < 0);
         releasing = ck_on && ck_paid >= 0;
         do_wr     = book_valid && !dup && !full && !releasing;
         e_err = 0; e_code = 0;
         if (book_valid && (dup || full)) begin
            e_err  = 1;
            e_code = dup ? 2'b10 : 2'b01;
         end
         if (ck_on) begin
            if (ck_paid >= 0) begin
               m_valid[ck_k] = 0;
               ck_on = 0;
            end else if (ck_miss) begin
               ck_on = 0;
            end else if (ck_k < 0) begin
               j = cyc - ck_t0 - 1;
               if (m_valid[j] && m_id[j] == ck_idm) ck_k = j;
               else if (j == 7) begin
                  ck_miss = 1; e_err = 1; e_code = 2'b11;
               end
            end else if ((cyc - 1 >= ck_t0 + ck_k + 2) && pay_ack) begin
               ck_paid = cyc;
            end
         end else if (checkout) begin
            ck_on = 1; ck_t0 = cyc; ck_idm = checkout_id;
            ck_k = -1; ck_miss = 0; ck_paid = -1;
         end
         if (do_wr) begin
            m_valid[wr_idx] = 1;
            m_id[wr_idx]    = book_id;
            m_ac[wr_idx]    = book_ac;
            m_wifi[wr_idx]  = book_wifi;
            m_days[wr_idx]  = int'(book_days);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      bit [7:0] exp_occ;
      bit exp_bv, exp_rel;
      for (int i = 0; i < 8; i++) exp_occ[i] = m_valid[i];
      exp_rel = ck_on && ck_paid >= 0;
      exp_bv  = ck_on && ck_k >= 0 && cyc >= ck_t0 + ck_k + 2 && ck_paid < 0;
      check("occupied",   32'(occupied),   32'(exp_occ));
      check("busy",       32'(busy),       32'(ck_on));
      check("bill_valid", 32'(bill_valid), 32'(exp_bv));
      check("book_ready", 32'(book_ready), 32'((exp_occ != 8'hFF) && !exp_rel));
      check("err",        32'(err),        32'(e_err));
      check("err_code",   32'(err_code),   32'(e_code));
      if (exp_bv)
         check("bill", 32'(bill), 32'(charge_of(m_ac[ck_k], m_wifi[ck_k], m_days[ck_k])));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic book(input logic [3:0] id, input logic ac, input logic wifi, input logic [2:0] days);
      book_valid = 1'b1; book_id = id; book_ac = ac; book_wifi = wifi; book_days = days;
      tick();
      book_valid = 1'b0;
   endtask

   task automatic checkout_wait(input logic [3:0] id, output int lat);
      checkout = 1'b1; checkout_id = id;
      tick();
      checkout = 1'b0;
      lat = 1;
      while (bill_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic pay();
      pay_ack = 1'b1;
      tick();
      pay_ack = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int lat;
      book_valid = 0; book_id = 0; book_ac = 0; book_wifi = 0; book_days = 0;
      checkout = 0; checkout_id = 0; pay_ack = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_bill_valid", 32'(bill_valid), 32'd0);
      check("rst_occupied",   32'(occupied),   32'd0);
      check("rst_book_ready", 32'(book_ready), 32'd1);
      check("rst_err",        32'(err),        32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Not-found on an empty table; a second checkout while busy is ignored.
      checkout = 1'b1; checkout_id = 4'd9;
      tick();
      tick();
      checkout = 1'b0;
      lat = 2;
      while (err !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check("miss_err_latency", 32'(lat),      32'd9);
      check("miss_err_code",    32'(err_code), 32'd3);
      tick();
      check("miss_busy_low",    32'(busy),     32'd0);
      check("miss_err_oneshot", 32'(err),      32'd0);

      // Slot 0 guest: bill 1500 three cycles after checkout.
      book(4'd1, 1'b0, 1'b0, 3'd3);
      check("book1_occupied", 32'(occupied), 32'h01);
      checkout_wait(4'd1, lat);
      check("id1_latency", 32'(lat),  32'd3);
      check("id1_bill",    32'(bill), 32'd1500);
      tick(); tick();
      check("id1_bill_held", 32'(bill), 32'd1500);
      pay();
      check("id1_release_bv",    32'(bill_valid), 32'd0);
      check("id1_release_busy",  32'(busy),       32'd1);
      check("id1_release_ready", 32'(book_ready), 32'd0);
      tick();
      check("id1_freed", 32'(occupied), 32'h00);
      check("id1_idle",  32'(busy),     32'd0);

      // Slot 1 guest with AC+WiFi, 5 days.
      book(4'd5, 1'b0, 1'b1, 3'd1);
      book(4'd2, 1'b1, 1'b1, 3'd5);
      checkout_wait(4'd2, lat);
      check("id2_latency", 32'(lat),  32'd4);
      check("id2_bill",    32'(bill), 32'(BILL_ID2));
      pay();
      tick();

      // pay_ack while idle has no effect.
      pay();
      tick();

      book(4'd7, 1'b0, 1'b1, 3'd6);
      checkout_wait(4'd7, lat);
      check("id7_latency", 32'(lat),  32'd4);
      check("id7_bill",    32'(bill), 32'(BILL_ID7));
      pay();
      tick();

      // Fill the table (id5 already in slot 0), then overflow and duplicate.
      for (int i = 0; i < 7; i++) book(4'(10 + i), i[0], i[1], 3'(i + 1));
      check("full_occupied",   32'(occupied),   32'hFF);
      check("full_book_ready", 32'(book_ready), 32'd0);
      book(4'd3, 1'b1, 1'b0, 3'd2);
      check("full_err",      32'(err),      32'd1);
      check("full_err_code", 32'(err_code), 32'd1);
      check("full_no_store", 32'(occupied), 32'hFF);
      book(4'd5, 1'b0, 1'b0, 3'd1);
      check("dup_err",      32'(err),      32'd1);
      check("dup_err_code", 32'(err_code), 32'd2);
      tick();
      check("err_cleared", 32'(err), 32'd0);

      // id14 sits in slot 5.
      checkout_wait(4'd14, lat);
      check("id14_latency", 32'(lat), 32'd8);
      pay();
      tick();

      // Re-book id14 into slot 5 while the search is still at slot 0: it is found.
      checkout = 1'b1; checkout_id = 4'd14;
      tick();
      checkout = 1'b0;
      book(4'd14, 1'b1, 1'b0, 3'd7);
      lat = 2;
      while (bill_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check("late_book_latency", 32'(lat),  32'd8);
      check("late_book_bill",    32'(bill), 32'(BILL_ID14));
      pay();
      tick();

      // Reset while presenting a bill.
      checkout_wait(4'd10, lat);
      check("id10_latency", 32'(lat), 32'd4);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_bill_valid", 32'(bill_valid), 32'd0);
      check("midrst_occupied",   32'(occupied),   32'd0);
      check("midrst_busy",       32'(busy),       32'd0);
      tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      check("postrst_no_bill", 32'(bill_valid), 32'd0);
      check("postrst_idle",    32'(busy),       32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
